nibble_change_logger: RTL
=========================

NIBBLE_CHANGE_LOGGER -- requirements
Module: nibble_change_logger

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the event FIFO entry count (power of two, 2..16).
REQ-002 Parameter HOLD_W, default 8, SHALL set the width of the run-length field.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 q_in  input  4  SHALL carry the registered nibble from the upstream 4-bit flipflop stage (its q output), sampled every rising edge.
REQ-006 ev_valid  output  1  SHALL be high while the FIFO holds at least one event.
REQ-007 ev_data  output  4  SHALL carry the new nibble value of the head event.
REQ-008 ev_hold  output  HOLD_W  SHALL carry the run length of the previous value for the head event.
REQ-009 ev_ready  input  1  SHALL pop the head event on a rising edge where ev_valid and ev_ready are both high.
REQ-010 drop_cnt  output  8  SHALL count events discarded on overflow (present only under REQ-024).

Function
REQ-011 Block SHALL hold prev (4 bits) and run_len (HOLD_W bits), the count of consecutive samples equal to prev.
REQ-012 Sample with q_in == prev SHALL set run_len <= run_len+1, saturating at 2^HOLD_W-1.
REQ-013 Sample with q_in != prev SHALL push event {ev_data=q_in, ev_hold=run_len}, then set prev <= q_in and run_len <= 1.
REQ-014 Push latency SHALL be one edge: event pushed at edge k is visible on ev_valid/ev_data/ev_hold after edge k.
REQ-015 FIFO SHALL be first-word-fall-through; pops SHALL return events in push order.
REQ-016 When empty, ev_valid, ev_data and ev_hold SHALL all be 0.
REQ-017 Push while full with no pop in the same edge SHALL discard the new event and leave FIFO contents unchanged; prev/run_len still update per REQ-013.
REQ-018 Push while full with a simultaneous pop SHALL accept the push; occupancy stays DEPTH.
REQ-019 Simultaneous push and pop at any occupancy SHALL keep occupancy unchanged.
REQ-020 Pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished with an extra pointer bit.
REQ-021 ev_ready while ev_valid is low SHALL have no effect.

Reset
REQ-022 Asserting rst_n low SHALL immediately clear prev=0, run_len=0, FIFO pointers and occupancy, drop_cnt=0, forcing ev_valid, ev_data, ev_hold to 0.
REQ-023 Reset asserted mid-stream SHALL discard all queued events; the first post-reset sample with q_in != 0 SHALL produce an event with ev_hold = number of zero samples since reset release.

Configuration
REQ-024 Macro NIBBLE_CHANGE_LOGGER_DROP_CNT_EN defined: drop_cnt port SHALL exist and increment by 1 per discarded event (REQ-017), saturating at 255; undefined: port and counter SHALL be absent, drops silent.

Structure
REQ-025 Package nibble_log_pkg SHALL hold NIBBLE_W=4 and the event struct typedef {data, hold}.
REQ-026 FIFO SHALL be a sub-module named nibble_event_fifo (parameters DEPTH, entry width); change detection and run-length logic SHALL stay in the top module.

Verification
REQ-027 Reset, q_in=0 for 3 edges then 3 -> one event ev_data=3, ev_hold=3 after the 4th edge.
REQ-028 q_in sequence 0x3 x2, 0x7 x3, 0xE x3, 0xA x2 with ev_ready=1 -> events (3,n0),(7,2),(E,3),(A,3) in order, each for exactly one cycle.
REQ-029 ev_ready=0, 6 changes with DEPTH=4 -> 4 events retained in order, drop_cnt=2 (macro defined).
REQ-030 FIFO full, one change with ev_ready=1 on the same edge -> oldest popped, new event appended, drop_cnt unchanged.
REQ-031 q_in constant for 300 edges after a change (HOLD_W=8) -> next change reports ev_hold=255.
REQ-032 rst_n pulsed low mid-cycle with 3 events queued -> ev_valid=0 immediately, no events returned post-reset.

Source files
------------

// File: rtl/nibble_log_pkg.sv
// nibble_log_pkg: shared nibble width, default run-length width and event record.
package nibble_log_pkg;
  localparam int NIBBLE_W   = 4;
  localparam int HOLD_W_DEF = 8;
  typedef struct packed {
    logic [NIBBLE_W-1:0]   data;
    logic [HOLD_W_DEF-1:0] hold;
  } nibble_ev_t;
endpackage

// File: rtl/nibble_event_fifo.sv
// nibble_event_fifo: first-word-fall-through event queue; head reads as zero when empty.
// Drop strobe exists only with NIBBLE_CHANGE_LOGGER_DROP_CNT_EN.
module nibble_event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
`ifdef NIBBLE_CHANGE_LOGGER_DROP_CNT_EN
  , output logic       drop_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         full, do_pop, do_push;
  // Extra pointer bit separates full from empty when the indices coincide.
  always_comb begin
    valid_o = wr_q != rd_q;
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop_i && valid_o;
    do_push = push_i && (!full || do_pop);
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    data_o  = valid_o ? mem_q[rd_q[AW-1:0]] : '0;
  end
`ifdef NIBBLE_CHANGE_LOGGER_DROP_CNT_EN
  assign drop_o = push_i && !do_push;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
endmodule

// File: rtl/nibble_change_logger.sv
// nibble_change_logger: logs each change of the upstream nibble with the run length of the old value.
// Optional drop counter port enabled by NIBBLE_CHANGE_LOGGER_DROP_CNT_EN.
module nibble_change_logger
  import nibble_log_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int HOLD_W = HOLD_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NIBBLE_W-1:0] q_in,
  output logic                ev_valid,
  output logic [NIBBLE_W-1:0] ev_data,
  output logic [HOLD_W-1:0]   ev_hold,
  input  logic                ev_ready
`ifdef NIBBLE_CHANGE_LOGGER_DROP_CNT_EN
  , output logic [7:0]        drop_cnt
`endif
);
  logic [NIBBLE_W-1:0] prev_q, prev_d;
  logic [HOLD_W-1:0]   run_len_q, run_len_d;
  logic                change;
  // Run length restarts at one: the sample that changed the value is its first.
  always_comb begin
    change    = q_in != prev_q;
    prev_d    = q_in;
    run_len_d = change ? HOLD_W'(1) : (&run_len_q ? run_len_q : run_len_q + 1'b1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev_q    <= '0;
      run_len_q <= '0;
    end else begin
      prev_q    <= prev_d;
      run_len_q <= run_len_d;
    end
`ifdef NIBBLE_CHANGE_LOGGER_DROP_CNT_EN
  logic       drop;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  always_comb drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 1'b1 : drop_cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drop_cnt_q <= '0;
    else drop_cnt_q <= drop_cnt_d;
  assign drop_cnt = drop_cnt_q;
`endif
  nibble_event_fifo #(.DEPTH(DEPTH), .W(NIBBLE_W + HOLD_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (change),
    .data_i  ({q_in, run_len_q}),
    .pop_i   (ev_ready),
    .valid_o (ev_valid),
    .data_o  ({ev_data, ev_hold})
`ifdef NIBBLE_CHANGE_LOGGER_DROP_CNT_EN
    , .drop_o(drop)
`endif
  );
endmodule
